// File: rtl/example_consumer.sv
// example_consumer: rate-limited sink for the CPU-to-FPGA (C2F) queue.
//
// Accepts 64-bit QWs over a valid/ready handshake. Acceptance is paced by a
// fractional credit accumulator driven by rate_in (Reff = min(rate_in, 256),
// throughput Reff/256 QWs per cycle). Every accepted QW is folded into a
// 64-bit running checksum and counted. A one-cycle pulse marks each fully
// consumed chunk of CHUNK_QWS QWs.
//
// Ports:
//   pcieClk_in     clock, all state updates on the rising edge
//   pcieRst_in     synchronous active-high reset
//   rate_in        CONSUMER_RATE register (0 = disabled, >=256 = full rate)
//   c2fData_in     QW from the C2F buffer reader
//   c2fValid_in    c2fData_in is valid
//   c2fReady_out   consumer accepts this cycle (registered)
//   cksumClear_in  one-cycle pulse, clears checksum and QW count
//   checksum_out   running checksum, mod 2^64
//   qwCount_out    QWs accepted since reset/clear, wraps
//   chunkDone_out  one-cycle pulse after the last QW of each chunk
//   idle_out       registered: valid was low last cycle (so no fire either)
module example_consumer #(
  parameter int unsigned CHUNK_QWS     = 512,
  parameter int unsigned QWCOUNT_WIDTH = 32
) (
  input  logic                     pcieClk_in,
  input  logic                     pcieRst_in,
  input  logic [31:0]              rate_in,
  input  logic [63:0]              c2fData_in,
  input  logic                     c2fValid_in,
  output logic                     c2fReady_out,
  input  logic                     cksumClear_in,
  output logic [63:0]              checksum_out,
  output logic [QWCOUNT_WIDTH-1:0] qwCount_out,
  output logic                     chunkDone_out,
  output logic                     idle_out
);

  localparam int unsigned ChunkIdxW = (CHUNK_QWS > 1) ? $clog2(CHUNK_QWS) : 1;
  localparam logic [ChunkIdxW-1:0] ChunkLast = ChunkIdxW'(CHUNK_QWS - 1);

  logic [8:0]               r_acc;
  logic                     r_token;
  logic [ChunkIdxW-1:0]     r_chunk_idx;
  logic [63:0]              r_checksum;
  logic [QWCOUNT_WIDTH-1:0] r_qw_count;
  logic                     r_chunk_done;
  logic                     r_idle;

  logic [8:0]  w_reff;
  logic        w_fire;
  logic [9:0]  w_sum;
  logic [9:0]  w_sum_wrap;
  logic        w_chunk_last;

  always_comb begin
    w_reff       = (rate_in > 32'd256) ? 9'd256 : rate_in[8:0];
    w_fire       = c2fValid_in & r_token;
    w_sum        = {1'b0, r_acc} + {1'b0, w_reff};
    w_sum_wrap   = w_sum - 10'd256;
    w_chunk_last = (r_chunk_idx == ChunkLast);
  end

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      r_acc        <= 9'd0;
      r_token      <= 1'b0;
      r_chunk_idx  <= '0;
      r_checksum   <= 64'd0;
      r_qw_count   <= '0;
      r_chunk_done <= 1'b0;
      r_idle       <= 1'b1;
    end else begin
      // Credit only moves when the token is free or being spent; a held
      // token freezes the accumulator so no credit is lost while stalled.
      if (!r_token || w_fire) begin
        if (w_sum >= 10'd256) begin
          r_token <= 1'b1;
          r_acc   <= w_sum_wrap[8:0];
        end else begin
          r_token <= 1'b0;
          r_acc   <= w_sum[8:0];
        end
      end

      // Clear wins over accumulation, but a same-cycle fire still counts.
      if (cksumClear_in) begin
        r_checksum <= w_fire ? c2fData_in : 64'd0;
        r_qw_count <= w_fire ? QWCOUNT_WIDTH'(1) : '0;
      end else if (w_fire) begin
        r_checksum <= r_checksum + c2fData_in;
        r_qw_count <= r_qw_count + 1'b1;
      end

      // Chunk position follows the ring and is deliberately not cleared.
      if (w_fire) begin
        r_chunk_idx <= r_chunk_idx + 1'b1;
      end
      r_chunk_done <= w_fire & w_chunk_last;

      // A fire implies valid, so "no valid and no fire" reduces to ~valid.
      r_idle <= ~c2fValid_in;
    end
  end

  assign c2fReady_out  = r_token;
  assign checksum_out  = r_checksum;
  assign qwCount_out   = r_qw_count;
  assign chunkDone_out = r_chunk_done;
  assign idle_out      = r_idle;

endmodule

// File: tb/tb_example_consumer.sv
// Testbench for example_consumer: directed stimulus with a scoreboard.
// A predictor pushes the expected checksum/count/chunk-pulse for every
// handshake it sees; a separate monitor pops and compares once the DUT's
// registered outputs reflect that handshake.
module tb_example_consumer;

  localparam int unsigned Chunk = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rate = 32'd0;
  logic [63:0] data = 64'd0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic        ready;
  logic [63:0] ck;
  logic [31:0] cnt;
  logic        done;
  logic        idle;

  example_consumer #(
    .CHUNK_QWS    (Chunk),
    .QWCOUNT_WIDTH(32)
  ) dut (
    .pcieClk_in   (clk),
    .pcieRst_in   (rst),
    .rate_in      (rate),
    .c2fData_in   (data),
    .c2fValid_in  (valid),
    .c2fReady_out (ready),
    .cksumClear_in(clear),
    .checksum_out (ck),
    .qwCount_out  (cnt),
    .chunkDone_out(done),
    .idle_out     (idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fire_total = 0;
  int done_total = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [63:0] ck;
    logic [31:0] cnt;
    logic        done;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Predictor: inputs and ready are stable at the falling edge and describe
  // the handshake that the next rising edge will perform.
  logic [63:0] m_ck = 64'd0;
  logic [31:0] m_cnt = 32'd0;
  int unsigned m_idx = 0;
  always @(negedge clk) begin : predictor
    logic f;
    exp_t e;
    if (rst) begin
      m_ck  = 64'd0;
      m_cnt = 32'd0;
      m_idx = 0;
      q.delete();
    end else begin
      f = valid & ready;
      if (clear) begin
        m_ck  = f ? data : 64'd0;
        m_cnt = f ? 32'd1 : 32'd0;
      end else if (f) begin
        m_ck  = m_ck + data;
        m_cnt = m_cnt + 32'd1;
      end
      if (f) begin
        e.ck   = m_ck;
        e.cnt  = m_cnt;
        e.done = (m_idx == Chunk - 1);
        m_idx  = (m_idx + 1) % Chunk;
        q.push_back(e);
      end
    end
  end

  // Monitor: samples the handshake at the edge, compares just after it.
  always @(posedge clk) begin : monitor
    logic f;
    exp_t e;
    f = valid & ready & ~rst;
    #2;
    if (mon_en) begin
      if (f) begin
        fire_total++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got a fire expected none pending");
        end else begin
          e = q.pop_front();
          check("sb_checksum", ck, e.ck);
          check("sb_qw_count", 64'(cnt), 64'(e.cnt));
          check("sb_chunk_done", 64'(done), 64'(e.done));
        end
      end else begin
        check("chunk_done_quiet", 64'(done), 64'd0);
      end
      if (done) done_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until ready is seen high (sampled after each edge).
  task automatic wait_ready(output int k);
    k = 0;
    while (!ready && k < 600) begin
      tick();
      k++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready_timeout: got ready=0 expected ready=1 within 600 cycles");
    end
  endtask

  task automatic send(input logic [63:0] d, input logic clr);
    int k;
    data  = d;
    valid = 1'b1;
    clear = clr;
    wait_ready(k);
    tick();
    valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    int c;
    int b_fire;
    int b_done;
    logic [63:0] seq;

    repeat (2) tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_chunk_done", 64'(done), 64'd0);
    check("reset_idle", 64'(idle), 64'd1);
    check("reset_checksum", ck, 64'd0);
    check("reset_qw_count", 64'(cnt), 64'd0);

    // Rate 0: never ready even with valid held.
    tick();
    valid = 1'b1;
    data  = 64'h1234;
    repeat (1000) tick();
    check("rate0_fires", 64'(fire_total), 64'd0);
    check("rate0_checksum", ck, 64'd0);
    check("rate0_qw_count", 64'(cnt), 64'd0);
    check("rate0_ready", 64'(ready), 64'd0);

    // Full rate: two chunks of ones, one QW per cycle.
    data   = 64'd1;
    rate   = 32'd256;
    b_fire = fire_total;
    b_done = done_total;
    wait_ready(k);
    check("first_ready_r256", 64'(k), 64'd1);
    c = 1;
    repeat (2 * Chunk - 1) begin
      tick();
      if (ready) c++;
    end
    check("r256_ready_cycles", 64'(c), 64'(2 * Chunk));
    tick();
    valid = 1'b0;
    repeat (2) tick();
    check("r256_checksum", ck, 64'h400);
    check("r256_qw_count", 64'(cnt), 64'd1024);
    check("r256_fires", 64'(fire_total - b_fire), 64'd1024);
    check("r256_chunk_pulses", 64'(done_total - b_done), 64'd2);

    // Rate 64 from reset: first ready on the 4th edge, then every 4th.
    rst   = 1'b1;
    rate  = 32'd64;
    valid = 1'b1;
    data  = 64'h0123_4567_89ab_cdef;
    tick();
    rst = 1'b0;
    wait_ready(k);
    check("first_ready_r64", 64'(k), 64'd4);
    c = 1;
    repeat (399) begin
      tick();
      if (ready) c++;
    end
    check("r64_fires_in_400", 64'(c), 64'd100);

    // Rate above 256 clamps to full rate.
    rate = 32'd1000;
    wait_ready(k);
    check("first_ready_r1000", 64'(k), 64'd1);
    c = 1;
    repeat (399) begin
      tick();
      if (ready) c++;
    end
    check("r1000_fires_in_400", 64'(c), 64'd400);
    tick();
    valid = 1'b0;

    // Checksum wrap modulo 2^64, after a clear with no fire.
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_checksum", ck, 64'd0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h2, 1'b0);
    check("wrap_checksum", ck, 64'h1);
    check("wrap_qw_count", 64'(cnt), 64'd2);

    // Clear coincident with a fire keeps that QW.
    send(64'h55, 1'b1);
    check("clear_fire_checksum", ck, 64'h55);
    check("clear_fire_qw_count", 64'(cnt), 64'd1);

    // 503 QWs accepted since the last reset, so the 9th more ends the chunk.
    for (int i = 0; i < 8; i++) send(64'(i + 3), 1'b0);
    check("chunk_not_yet", 64'(done), 64'd0);
    send(64'hAA, 1'b0);
    check("chunk_idx_preserved", 64'(done), 64'd1);
    tick();

    // Random valid gaps at full rate.
    seq = 64'h9E37_79B9_7F4A_7C15;
    for (int i = 0; i < 300; i++) begin
      valid = 1'($urandom_range(0, 1));
      data  = seq;
      seq   = seq * 64'd6364136223846793005 + 64'd1442695040888963407;
      tick();
    end
    valid = 1'b0;
    repeat (2) tick();
    check("random_checksum", ck, m_ck);
    check("random_qw_count", 64'(cnt), 64'(m_cnt));

    // Rate dropped to 0 with the token held: exactly one more QW.
    rate   = 32'd0;
    b_fire = fire_total;
    tick();
    valid = 1'b1;
    data  = 64'h77;
    repeat (20) tick();
    check("drop_rate_fires", 64'(fire_total - b_fire), 64'd1);
    check("drop_rate_ready", 64'(ready), 64'd0);
    valid = 1'b0;

    // Reset mid-stream overrides an in-flight QW.
    rate  = 32'd256;
    valid = 1'b1;
    data  = 64'h7;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_checksum", ck, 64'd0);
    check("midrst_qw_count", 64'(cnt), 64'd0);
    check("midrst_chunk_done", 64'(done), 64'd0);
    check("midrst_idle", 64'(idle), 64'd1);
    rst   = 1'b0;
    valid = 1'b0;
    repeat (3) tick();
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/example_consumer.md
# example_consumer

Rate-limited sink for the CPU→FPGA (C2F) queue: accepts 64-bit QWs from the C2F buffer reader through a valid/ready handshake. It paces acceptance with a fractional credit accumulator driven by the CONSUMER_RATE register, and folds every accepted QW into a 64-bit checksum exposed as CHECKSUM_LSW/MSW. It pulses once per fully-consumed chunk so the C2F read-pointer logic can advance and DMA the new rdPtr to host metrics memory.

## Interface
- CHUNK_QWS, 512: QWs per C2F chunk (C2F_CHUNKSIZE/8); power of two, ≥2.
- QWCOUNT_WIDTH, 32: width of the accepted-QW counter.
- pcieClk_in  in  1  sole clock; every register updates on its rising edge.
- pcieRst_in  in  1  reset, synchronous, active-high.
- rate_in  in  32  CONSUMER_RATE register value, level. 0 = DISABLED; 256 = full rate; values >256 clamp to 256 (Reff = min(rate_in, 256)).
- c2fData_in  in  64  QW from C2F buffer reader.
- c2fValid_in  in  1  c2fData_in valid.
- c2fReady_out  out  1  consumer accepts this cycle; fire = c2fValid_in & c2fReady_out.
- cksumClear_in  in  1  one-cycle pulse; clears checksum and QW count.
- checksum_out  out  64  running checksum (LSW = [31:0], MSW = [63:32]).
- qwCount_out  out  QWCOUNT_WIDTH  QWs accepted since reset/clear, wraps.
- chunkDone_out  out  1  one-cycle pulse per CHUNK_QWS QWs accepted.
- idle_out  out  1  high when c2fValid_in is low and no fire occurred in the previous cycle.

## Operation
- State: acc (9-bit credit accumulator), token (1 bit), chunkIdx (log2(CHUNK_QWS) bits), checksum (64), qwCount.
- c2fReady_out = token (registered; no combinational path from c2fValid_in).
- Credit update, evaluated each cycle: if token==0 or fire, then s = acc + Reff. If s ≥ 256: token←1, acc←s−256. Otherwise token←0, acc←s. If token==1 and no fire, acc and token hold.
- Resulting throughput: Reff/256 QWs per cycle. 256 → token stays 1 (one QW every cycle); 128 → ready every 2nd cycle; 1 → one in 256.
- rate_in dropping to 0 while token==1: token stays until one QW is consumed, then clears and stays 0; acc is retained.
- Checksum: on fire, checksum ← (checksum + c2fData_in) mod 2^64. qwCount ← qwCount+1 (wraps).
- cksumClear_in: checksum←0, qwCount←0. If a fire occurs in the same cycle: checksum←c2fData_in, qwCount←1.
- cksumClear_in does not touch acc, token or chunkIdx; chunk alignment with the ring is preserved.
- Chunk tracking: on fire, chunkIdx←chunkIdx+1 (wraps at CHUNK_QWS). When the fire occurs with chunkIdx==CHUNK_QWS−1, chunkDone_out pulses high for exactly one cycle, the next cycle.
- Data is never dropped or duplicated: every fire contributes exactly once to checksum, qwCount and chunkIdx.

## Timing
- Reset (pcieRst_in high at an edge): acc=0, token=0, chunkIdx=0, checksum=0, qwCount=0. After that edge: c2fReady_out=0, chunkDone_out=0, idle_out=1.
- Reset mid-operation overrides everything, including a simultaneous fire. The in-flight QW is not consumed (ready is 0 after the reset edge).
- First ready after rate_in becomes R>0 from reset: cycle k where k·R ≥ 256. k=1 for R=256, i.e. ready high 1 cycle after the rate write is visible.
- checksum_out, qwCount_out, chunkDone_out and idle_out are registered: they reflect a fire one cycle later.
- Upstream may hold c2fValid_in indefinitely; the consumer never requires valid before asserting ready.

## Test plan
- Reset, rate_in=0, c2fValid_in=1 for 1000 cycles → c2fReady_out stays 0, checksum_out=0, qwCount_out=0, no chunkDone_out.
- rate_in=256, stream 2·CHUNK_QWS QWs of value 1 with valid held high → one fire per cycle, checksum_out=0x400 (CHUNK_QWS=512), exactly two chunkDone_out pulses, each one cycle after QW 511 and QW 1023.
- rate_in=64, continuous valid, 400 cycles → exactly 100 fires (ready every 4th cycle); rate_in=1000 → behaves as 256.
- Data 0xFFFFFFFFFFFFFFFF then 0x2 → checksum_out=0x1 (mod-2^64 wrap); cksumClear_in in the same cycle as a fire of 0x55 → checksum_out=0x55, qwCount_out=1, chunkIdx unaffected.
- Random valid gaps at rate 256 against a scoreboard summing SEQ64 → checksum matches the model; with the C2F buffer preloaded with the NUM_CHUNKS−1 chunk SEQ64 pattern, CHECKSUM = 0x305B31B74AFB4CBE.
- Rate dropped to 0 while token=1, then valid asserted → exactly one QW accepted, then ready stays 0; pcieRst_in asserted mid-stream → all outputs return to reset values on the next edge.
